// File: rtl/sw_irq_service_seq.sv
// -----------------------------------------------------------------------------
// sw_irq_service_seq
//
// AXI4-Lite master that drives the 4-switch controller register file when no
// processor driver exists. After reset it writes the switch mask and then sets
// the IRQ enable. It then services each IRQ:
//   1. read the event register
//   2. read the state register
//   3. present the event on a valid/ready stream
//   4. write the event bits back to acknowledge them (write-1-to-clear)
//   5. wait two guard cycles before looking at irq again
// A mask rewrite requested through cfg_valid takes priority over IRQ service.
//
// Ports
//   clk, reset             single rising-edge clock, async active-high reset
//   irq                    level interrupt from the switch controller
//   cfg_mask, cfg_valid    request to rewrite the switch mask (last one wins)
//   evt_data, evt_state,
//   evt_valid, evt_ready   event stream towards PL consumers
//   busy                   sequencer is not idle
//   err_resp, err_timeout  sticky error flags
//   m_aw*, m_w*, m_b*,
//   m_ar*, m_r*            AXI4-Lite master port
// -----------------------------------------------------------------------------
module sw_irq_service_seq #(
   parameter logic [3:0]  ADDR_CTRL      = 4'h0,
   parameter logic [3:0]  ADDR_MASK      = 4'h4,
   parameter logic [3:0]  ADDR_EVENT     = 4'h8,
   parameter logic [3:0]  ADDR_STATE     = 4'hC,
   parameter logic [3:0]  INIT_MASK      = 4'hF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq,
   input  logic [3:0]  cfg_mask,
   input  logic        cfg_valid,
   output logic [3:0]  evt_data,
   output logic [3:0]  evt_state,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic        busy,
   output logic        err_resp,
   output logic        err_timeout,
   output logic [3:0]  m_awaddr,
   output logic [2:0]  m_awprot,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [3:0]  m_araddr,
   output logic [2:0]  m_arprot,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      S_INIT_MASK,
      S_INIT_CTRL,
      S_IDLE,
      S_CFG_MASK,
      S_RD_EVENT,
      S_RD_STATE,
      S_PUSH,
      S_WR_ACK,
      S_GUARD
   } state_t;

   state_t      state_reg, state_next;

   logic        issued_reg;
   logic        awvalid_reg, wvalid_reg, bready_reg;
   logic        arvalid_reg, rready_reg;
   logic [3:0]  awaddr_reg, araddr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  evt_data_reg, evt_state_reg;
   logic        evt_valid_reg;
   logic        cfg_pending_reg;
   logic [3:0]  cfg_mask_reg;
   logic [7:0]  tmo_cnt_reg;
   logic        guard_cnt_reg;
   logic        err_resp_reg, err_timeout_reg;

   logic        is_wr_state, is_rd_state;
   logic        wr_done, rd_done, issue_now, txn_wait;
   logic [3:0]  wr_addr_sel, rd_addr_sel;
   logic [31:0] wr_data_sel;

   // Only the low nibble of read data carries register content.
   logic        unused_rdata_bits;
   assign unused_rdata_bits = ^m_rdata[31:4];

   assign wr_done = m_bvalid & bready_reg;
   assign rd_done = m_rvalid & rready_reg;

   // Address/data of the transaction belonging to the current state.
   always_comb begin
      is_wr_state = 1'b0;
      is_rd_state = 1'b0;
      wr_addr_sel = ADDR_MASK;
      wr_data_sel = 32'd0;
      rd_addr_sel = ADDR_EVENT;
      case (state_reg)
         S_INIT_MASK: begin is_wr_state = 1'b1; wr_addr_sel = ADDR_MASK;  wr_data_sel = {28'd0, INIT_MASK};    end
         S_INIT_CTRL: begin is_wr_state = 1'b1; wr_addr_sel = ADDR_CTRL;  wr_data_sel = 32'd1;                 end
         S_CFG_MASK:  begin is_wr_state = 1'b1; wr_addr_sel = ADDR_MASK;  wr_data_sel = {28'd0, cfg_mask_reg}; end
         S_WR_ACK:    begin is_wr_state = 1'b1; wr_addr_sel = ADDR_EVENT; wr_data_sel = {28'd0, evt_data_reg}; end
         S_RD_EVENT:  begin is_rd_state = 1'b1; rd_addr_sel = ADDR_EVENT; end
         S_RD_STATE:  begin is_rd_state = 1'b1; rd_addr_sel = ADDR_STATE; end
         default: ;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_INIT_MASK: if (wr_done) state_next = S_INIT_CTRL;
         S_INIT_CTRL: if (wr_done) state_next = S_IDLE;
         S_IDLE: begin
            if (cfg_pending_reg)  state_next = S_CFG_MASK;
            else if (irq)         state_next = S_RD_EVENT;
         end
         S_CFG_MASK:  if (wr_done) state_next = S_IDLE;
         S_RD_EVENT: begin
            // An empty event register means a spurious IRQ: nothing to push or ack.
            if (rd_done) state_next = (m_rdata[3:0] == 4'd0) ? S_GUARD : S_RD_STATE;
         end
         S_RD_STATE:  if (rd_done) state_next = S_PUSH;
         S_PUSH:      if (evt_valid_reg && evt_ready) state_next = S_WR_ACK;
         S_WR_ACK:    if (wr_done) state_next = S_GUARD;
         S_GUARD:     if (guard_cnt_reg) state_next = S_IDLE;
         default:     state_next = S_INIT_MASK;
      endcase
   end

   // A bus state launches its transaction one cycle after it is entered;
   // the issued flag stays set until the state is left.
   assign issue_now = (is_wr_state | is_rd_state) & ~issued_reg & (state_next == state_reg);
   assign txn_wait  = issued_reg & ((is_wr_state & ~wr_done) | (is_rd_state & ~rd_done));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_INIT_MASK;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issued_reg      <= 1'b0;
         awvalid_reg     <= 1'b0;
         wvalid_reg      <= 1'b0;
         bready_reg      <= 1'b0;
         arvalid_reg     <= 1'b0;
         rready_reg      <= 1'b0;
         awaddr_reg      <= 4'd0;
         araddr_reg      <= 4'd0;
         wdata_reg       <= 32'd0;
         evt_data_reg    <= 4'd0;
         evt_state_reg   <= 4'd0;
         evt_valid_reg   <= 1'b0;
         cfg_pending_reg <= 1'b0;
         cfg_mask_reg    <= 4'd0;
         tmo_cnt_reg     <= 8'd0;
         guard_cnt_reg   <= 1'b0;
         err_resp_reg    <= 1'b0;
         err_timeout_reg <= 1'b0;
      end else begin
         if (state_next != state_reg) begin
            issued_reg <= 1'b0;
         end else if (issue_now) begin
            issued_reg  <= 1'b1;
            tmo_cnt_reg <= 8'd0;
            if (is_wr_state) begin
               awvalid_reg <= 1'b1;
               wvalid_reg  <= 1'b1;
               bready_reg  <= 1'b1;
               awaddr_reg  <= wr_addr_sel;
               wdata_reg   <= wr_data_sel;
            end else begin
               arvalid_reg <= 1'b1;
               rready_reg  <= 1'b1;
               araddr_reg  <= rd_addr_sel;
            end
         end

         // Each channel drops independently on its own handshake.
         if (awvalid_reg && m_awready) awvalid_reg <= 1'b0;
         if (wvalid_reg && m_wready)   wvalid_reg  <= 1'b0;
         if (wr_done)                  bready_reg  <= 1'b0;
         if (arvalid_reg && m_arready) arvalid_reg <= 1'b0;
         if (rd_done)                  rready_reg  <= 1'b0;

         // Saturating per-transaction watchdog; it only flags, never aborts.
         if (txn_wait) begin
            if (tmo_cnt_reg == TMO_LIMIT) err_timeout_reg <= 1'b1;
            else                          tmo_cnt_reg     <= tmo_cnt_reg + 8'd1;
         end

         if ((wr_done && m_bresp != 2'b00) || (rd_done && m_rresp != 2'b00))
            err_resp_reg <= 1'b1;

         if (state_reg == S_RD_EVENT && rd_done) evt_data_reg <= m_rdata[3:0];
         if (state_reg == S_RD_STATE && rd_done) begin
            evt_state_reg <= m_rdata[3:0];
            evt_valid_reg <= 1'b1;
         end else if (evt_valid_reg && evt_ready) begin
            evt_valid_reg <= 1'b0;
         end

         // A new request arriving in the same cycle as the mask write is
         // issued stays pending, so it gets its own write afterwards.
         if (cfg_valid) begin
            cfg_pending_reg <= 1'b1;
            cfg_mask_reg    <= cfg_mask;
         end else if (state_reg == S_CFG_MASK && issue_now) begin
            cfg_pending_reg <= 1'b0;
         end

         if (state_reg == S_GUARD) guard_cnt_reg <= ~guard_cnt_reg;
         else                      guard_cnt_reg <= 1'b0;
      end
   end

   assign m_awaddr    = awaddr_reg;
   assign m_awprot    = 3'b000;
   assign m_awvalid   = awvalid_reg;
   assign m_wdata     = wdata_reg;
   assign m_wstrb     = 4'hF;
   assign m_wvalid    = wvalid_reg;
   assign m_bready    = bready_reg;
   assign m_araddr    = araddr_reg;
   assign m_arprot    = 3'b000;
   assign m_arvalid   = arvalid_reg;
   assign m_rready    = rready_reg;
   assign evt_data    = evt_data_reg;
   assign evt_state   = evt_state_reg;
   assign evt_valid   = evt_valid_reg;
   assign busy        = (state_reg != S_IDLE);
   assign err_resp    = err_resp_reg;
   assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_sw_irq_service_seq.sv
// -----------------------------------------------------------------------------
// tb_sw_irq_service_seq
//
// Bench for sw_irq_service_seq. A small AXI4-Lite slave model stands in for
// the switch controller: control, mask, event (write-1-to-clear) and state
// registers, a log of every write, and knobs for AW backpressure and an
// error response on a chosen write. irq is high while the event register is
// non-zero, or while a spurious IRQ is being forced.
// -----------------------------------------------------------------------------
module tb_sw_irq_service_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        irq;
   logic [3:0]  cfg_mask = 4'd0;
   logic        cfg_valid = 1'b0;
   logic [3:0]  evt_data, evt_state;
   logic        evt_valid;
   logic        evt_ready = 1'b1;
   logic        busy, err_resp, err_timeout;
   logic [3:0]  m_awaddr;
   logic [2:0]  m_awprot;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid, m_wready;
   logic [1:0]  m_bresp = 2'b00;
   logic        m_bvalid = 1'b0;
   logic        m_bready;
   logic [3:0]  m_araddr;
   logic [2:0]  m_arprot;
   logic        m_arvalid, m_arready;
   logic [31:0] m_rdata = 32'd0;
   logic [1:0]  m_rresp = 2'b00;
   logic        m_rvalid = 1'b0;
   logic        m_rready;

   always #5 clk = ~clk;

   sw_irq_service_seq dut (
      .clk(clk), .reset(reset), .irq(irq),
      .cfg_mask(cfg_mask), .cfg_valid(cfg_valid),
      .evt_data(evt_data), .evt_state(evt_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .busy(busy), .err_resp(err_resp), .err_timeout(err_timeout),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   // ---------------- slave model ----------------
   logic        awready_en = 1'b1;
   int          inject_idx = -1;      // write index that gets SLVERR
   logic        spur_irq = 1'b0;
   logic [3:0]  evt_src = 4'd0;       // event value to load into the register
   int          evt_gen = 0;          // bump to load evt_src
   int          seen_gen = 0;
   logic [3:0]  event_val = 4'd0;
   logic [3:0]  state_val = 4'd0;
   logic [3:0]  mask_val = 4'd0;
   logic        ctrl_val = 1'b0;
   logic        aw_got = 1'b0, w_got = 1'b0;
   logic [3:0]  aw_addr_l = 4'd0;
   logic [31:0] w_data_l = 32'd0;
   logic [3:0]  wr_addr_log [64];
   logic [31:0] wr_data_log [64];
   int          wr_cnt = 0;

   assign m_awready = awready_en & ~aw_got;
   assign m_wready  = ~w_got;
   assign m_arready = ~m_rvalid;
   assign irq       = (event_val != 4'd0) | spur_irq;

   always @(posedge clk) begin
      if (evt_gen != seen_gen) begin
         event_val <= evt_src;
         seen_gen  <= evt_gen;
      end
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_addr_l <= m_awaddr; end
      if (m_wvalid && m_wready)   begin w_got  <= 1'b1; w_data_l  <= m_wdata;  end
      if (aw_got && w_got && !m_bvalid) begin
         m_bvalid <= 1'b1;
         m_bresp  <= (wr_cnt == inject_idx) ? 2'b10 : 2'b00;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         if (wr_cnt < 64) begin
            wr_addr_log[wr_cnt] <= aw_addr_l;
            wr_data_log[wr_cnt] <= w_data_l;
         end
         wr_cnt <= wr_cnt + 1;
         $display("AXI write #%0d: addr=0x%0h data=0x%0h", wr_cnt, aw_addr_l, w_data_l);
         case (aw_addr_l)
            4'h0: ctrl_val <= w_data_l[0];
            4'h4: mask_val <= w_data_l[3:0];
            4'h8: if (evt_gen == seen_gen) event_val <= event_val & ~w_data_l[3:0];
            default: ;
         endcase
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
         m_rvalid <= 1'b1;
         m_rresp  <= 2'b00;
         case (m_araddr)
            4'h0:    m_rdata <= {31'd0, ctrl_val};
            4'h4:    m_rdata <= {28'd0, mask_val};
            4'h8:    m_rdata <= {28'd0, event_val};
            4'hC:    m_rdata <= {28'd0, state_val};
            default: m_rdata <= 32'd0;
         endcase
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
   end

   // ---------------- stream monitor ----------------
   int         hs_cnt = 0;
   int         valid_cycles = 0;
   logic [3:0] last_data = 4'd0, last_state = 4'd0;

   always @(posedge clk) begin
      if (evt_valid) valid_cycles <= valid_cycles + 1;
      if (evt_valid && evt_ready) begin
         hs_cnt     <= hs_cnt + 1;
         last_data  <= evt_data;
         last_state <= evt_state;
      end
   end

   // ---------------- checking ----------------
   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_busy(input logic level, input int max, input string name);
      int n = 0;
      while (busy !== level && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'(level));
   endtask

   task automatic check_write(input string name, input int idx, input logic [3:0] addr, input logic [31:0] data);
      check({name, "_addr"}, 32'(wr_addr_log[idx & 63]), 32'(addr));
      check({name, "_data"}, wr_data_log[idx & 63], data);
   endtask

   typedef struct {
      logic [3:0] evt;
      logic [3:0] st;
      logic       spur;
      int         exp_beats;
      logic [3:0] exp_data;
      logic [3:0] exp_state;
      int         exp_writes;
      logic [3:0] exp_ack;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int w0, h0, v0, n, hold_bad;

      vecs[0] = '{evt: 4'b0100, st: 4'b0101, spur: 1'b0, exp_beats: 1, exp_data: 4'h4, exp_state: 4'h5, exp_writes: 1, exp_ack: 4'h4};
      vecs[1] = '{evt: 4'b0001, st: 4'b1110, spur: 1'b0, exp_beats: 1, exp_data: 4'h1, exp_state: 4'hE, exp_writes: 1, exp_ack: 4'h1};
      vecs[2] = '{evt: 4'b1010, st: 4'b0011, spur: 1'b0, exp_beats: 1, exp_data: 4'hA, exp_state: 4'h3, exp_writes: 1, exp_ack: 4'hA};
      vecs[3] = '{evt: 4'b0000, st: 4'b0110, spur: 1'b1, exp_beats: 0, exp_data: 4'h0, exp_state: 4'h0, exp_writes: 0, exp_ack: 4'h0};
      vecs[4] = '{evt: 4'b1111, st: 4'b0000, spur: 1'b0, exp_beats: 1, exp_data: 4'hF, exp_state: 4'h0, exp_writes: 1, exp_ack: 4'hF};

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_busy",      32'(busy), 32'd1);
      check("rst_awvalid",   32'(m_awvalid), 32'd0);
      check("rst_wvalid",    32'(m_wvalid), 32'd0);
      check("rst_bready",    32'(m_bready), 32'd0);
      check("rst_arvalid",   32'(m_arvalid), 32'd0);
      check("rst_rready",    32'(m_rready), 32'd0);
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_evt_bits",  32'({evt_data, evt_state}), 32'd0);
      check("rst_errs",      32'({err_resp, err_timeout}), 32'd0);
      check("prot_strb",     32'({m_awprot, m_arprot, m_wstrb}), 32'h00F);

      // ---- init sequence ----
      w0 = wr_cnt;
      reset = 1'b0;
      wait_busy(1'b0, 100, "init_done");
      $display("init: %0d writes, busy=%0b", wr_cnt - w0, busy);
      check("init_wr_cnt", 32'(wr_cnt - w0), 32'd2);
      check_write("init_mask", w0, 4'h4, 32'hF);
      check_write("init_ctrl", w0 + 1, 4'h0, 32'h1);
      check("init_regs", 32'({ctrl_val, mask_val}), 32'h1F);

      // ---- table-driven IRQ service ----
      for (int i = 0; i < 5; i++) begin
         w0 = wr_cnt; h0 = hs_cnt; v0 = valid_cycles;
         evt_src   = vecs[i].evt;
         state_val = vecs[i].st;
         evt_gen++;
         spur_irq  = vecs[i].spur;
         wait_busy(1'b1, 20, "row_start");
         spur_irq = 1'b0;
         wait_busy(1'b0, 300, "row_done");
         $display("row %0d: beats=%0d data=0x%0h state=0x%0h writes=%0d", i, hs_cnt - h0, last_data, last_state, wr_cnt - w0);
         check("row_beats", 32'(hs_cnt - h0), 32'(vecs[i].exp_beats));
         check("row_writes", 32'(wr_cnt - w0), 32'(vecs[i].exp_writes));
         if (vecs[i].exp_beats > 0) begin
            check("row_evt_data", 32'(last_data), 32'(vecs[i].exp_data));
            check("row_evt_state", 32'(last_state), 32'(vecs[i].exp_state));
            check_write("row_ack", w0, 4'h8, {28'd0, vecs[i].exp_ack});
         end else begin
            check("row_spur_no_valid", 32'(valid_cycles - v0), 32'd0);
         end
         check("row_irq_low", 32'(irq), 32'd0);
      end

      // ---- consumer backpressure during PUSH ----
      evt_ready = 1'b0;
      w0 = wr_cnt; h0 = hs_cnt;
      evt_src = 4'b1000; state_val = 4'b0010; evt_gen++;
      n = 0;
      while (evt_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("bp_valid_seen", 32'(evt_valid), 32'd1);
      hold_bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!(evt_valid === 1'b1 && evt_data === 4'h8 && evt_state === 4'h2 && wr_cnt == w0))
            hold_bad++;
      end
      check("bp_hold_violations", 32'(hold_bad), 32'd0);
      evt_ready = 1'b1;
      wait_busy(1'b0, 100, "bp_done");
      $display("backpressure: beats=%0d writes=%0d", hs_cnt - h0, wr_cnt - w0);
      check("bp_beats", 32'(hs_cnt - h0), 32'd1);
      check("bp_writes", 32'(wr_cnt - w0), 32'd1);
      check_write("bp_ack", w0, 4'h8, 32'h8);

      // ---- mask rewrite requests while busy, irq pending at IDLE ----
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      w0 = wr_cnt; h0 = hs_cnt;
      cfg_valid = 1'b1; cfg_mask = 4'h3;
      evt_src = 4'b0010; state_val = 4'b1001; evt_gen++;
      @(negedge clk) cfg_mask = 4'h6;
      @(negedge clk) cfg_valid = 1'b0;
      n = 0;
      while (wr_cnt < w0 + 4 && n < 200) begin @(negedge clk); n++; end
      check("cfg_wr_reached", 32'(wr_cnt >= w0 + 4), 32'd1);
      wait_busy(1'b0, 100, "cfg_done");
      $display("cfg: writes=%0d beats=%0d mask=0x%0h", wr_cnt - w0, hs_cnt - h0, mask_val);
      check("cfg_wr_cnt", 32'(wr_cnt - w0), 32'd4);
      check_write("cfg_init_mask", w0, 4'h4, 32'hF);
      check_write("cfg_init_ctrl", w0 + 1, 4'h0, 32'h1);
      check_write("cfg_mask_wr", w0 + 2, 4'h4, 32'h6);
      check_write("cfg_ack", w0 + 3, 4'h8, 32'h2);
      check("cfg_evt", 32'({last_data, last_state}), 32'h29);

      // ---- error response and AW timeout during init ----
      inject_idx = wr_cnt;
      awready_en = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      w0 = wr_cnt;
      repeat (300) @(negedge clk);
      $display("stall: awvalid=%0b err_timeout=%0b busy=%0b", m_awvalid, err_timeout, busy);
      check("tmo_flag", 32'(err_timeout), 32'd1);
      check("tmo_awvalid_held", 32'({m_awvalid, m_awaddr}), 32'h14);
      check("tmo_busy", 32'(busy), 32'd1);
      awready_en = 1'b1;
      wait_busy(1'b0, 100, "err_done");
      check("err_resp_flag", 32'(err_resp), 32'd1);
      check("err_tmo_sticky", 32'(err_timeout), 32'd1);
      check("err_wr_cnt", 32'(wr_cnt - w0), 32'd2);
      check_write("err_init_mask", w0, 4'h4, 32'hF);
      check_write("err_init_ctrl", w0 + 1, 4'h0, 32'h1);

      // ---- reset clears sticky errors ----
      inject_idx = -1;
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("rst2_errs", 32'({err_resp, err_timeout, busy}), 32'h1);
      reset = 1'b0;
      wait_busy(1'b0, 100, "rst2_init_done");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
